// File: rtl/solution_topk.sv
// Keeps the K lowest-cost candidates in a sorted register array and drains them as a ranked stream.
// Optional macro SOLUTION_TOPK_DROP_CNT_EN enables the drain-time dropped-candidate counter.
module solution_topk #(
  parameter int unsigned PD    = 12,
  parameter int unsigned P     = 22,
  parameter int unsigned K     = 4,
  parameter int unsigned IDX_W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 valid_i,
  input  logic [PD+P-1:0]                      d0_res,
  input  logic [PD+P-1:0]                      d1_res,
  input  logic [PD+P-1:0]                      d2_res,
  input  logic [3+P-1:0]                       fx_res,
  input  logic [IDX_W-1:0]                     p0_idx_i,
  input  logic                                 eval_done_i,
  output logic [3+P-1:0]                       fx_best_o,
  output logic [IDX_W-1:0]                     p0_idx_best_o,
  output logic [$clog2(K+1)-1:0]               count_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [PD+P-1:0]                      out_d0,
  output logic [PD+P-1:0]                      out_d1,
  output logic [PD+P-1:0]                      out_d2,
  output logic [3+P-1:0]                       out_fx,
  output logic [IDX_W-1:0]                     out_idx,
  output logic [((K > 1) ? $clog2(K) : 1)-1:0] out_rank,
  output logic                                 out_last,
  output logic                                 done_o,
  output logic [15:0]                          drop_cnt_o
);

  localparam int unsigned DW = PD + P;
  localparam int unsigned FW = 3 + P;
  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t          state;
  logic [RW-1:0]   rank;
  logic [CW-1:0]   count;

  logic [FW-1:0]    s_fx  [K];
  logic [DW-1:0]    s_d0  [K];
  logic [DW-1:0]    s_d1  [K];
  logic [DW-1:0]    s_d2  [K];
  logic [IDX_W-1:0] s_idx [K];

  logic [FW-1:0]    n_fx  [K];
  logic [DW-1:0]    n_d0  [K];
  logic [DW-1:0]    n_d1  [K];
  logic [DW-1:0]    n_d2  [K];
  logic [IDX_W-1:0] n_idx [K];

  logic [K-1:0]     le;
  logic             ins;
  logic [CW-1:0]    count_nxt;
  logic             last_c;

  // Sorted insertion: valid slots with fx <= candidate form a prefix; slots after it shift down by one.
  always_comb begin
    logic carry;
    logic [FW-1:0]    sh_fx  [K];
    logic [DW-1:0]    sh_d0  [K];
    logic [DW-1:0]    sh_d1  [K];
    logic [DW-1:0]    sh_d2  [K];
    logic [IDX_W-1:0] sh_idx [K];
    le     = '0;
    carry  = 1'b1;
    sh_fx[0]  = fx_res;
    sh_d0[0]  = d0_res;
    sh_d1[0]  = d1_res;
    sh_d2[0]  = d2_res;
    sh_idx[0] = p0_idx_i;
    for (int i = 1; i < K; i++) begin
      sh_fx[i]  = s_fx[i-1];
      sh_d0[i]  = s_d0[i-1];
      sh_d1[i]  = s_d1[i-1];
      sh_d2[i]  = s_d2[i-1];
      sh_idx[i] = s_idx[i-1];
    end
    for (int i = 0; i < K; i++) begin
      le[i] = (count > CW'(i)) && (s_fx[i] <= fx_res);
      if (le[i]) begin
        n_fx[i]  = s_fx[i];
        n_d0[i]  = s_d0[i];
        n_d1[i]  = s_d1[i];
        n_d2[i]  = s_d2[i];
        n_idx[i] = s_idx[i];
      end else if (carry) begin
        n_fx[i]  = fx_res;
        n_d0[i]  = d0_res;
        n_d1[i]  = d1_res;
        n_d2[i]  = d2_res;
        n_idx[i] = p0_idx_i;
      end else begin
        n_fx[i]  = sh_fx[i];
        n_d0[i]  = sh_d0[i];
        n_d1[i]  = sh_d1[i];
        n_d2[i]  = sh_d2[i];
        n_idx[i] = sh_idx[i];
      end
      carry = le[i];
    end
  end

  assign ins       = valid_i && (state == COLLECT) && !le[K-1];
  assign count_nxt = !ins ? count : ((count == CW'(K)) ? count : count + CW'(1));
  assign last_c    = (state == DRAIN) && ((count - CW'(1)) == CW'(rank));

  // Control and slot storage; a last-beat handshake restores the reset contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= COLLECT;
      rank   <= '0;
      count  <= '0;
      done_o <= 1'b0;
      for (int i = 0; i < K; i++) begin
        s_fx[i]  <= '1;
        s_d0[i]  <= '0;
        s_d1[i]  <= '0;
        s_d2[i]  <= '0;
        s_idx[i] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      case (state)
        COLLECT: begin
          if (ins) begin
            count <= count_nxt;
            for (int i = 0; i < K; i++) begin
              s_fx[i]  <= n_fx[i];
              s_d0[i]  <= n_d0[i];
              s_d1[i]  <= n_d1[i];
              s_d2[i]  <= n_d2[i];
              s_idx[i] <= n_idx[i];
            end
          end
          if (eval_done_i) begin
            if (count_nxt == '0) begin
              done_o <= 1'b1;
            end else begin
              state <= DRAIN;
              rank  <= '0;
            end
          end
        end
        DRAIN: begin
          if (out_ready_i) begin
            if (last_c) begin
              state  <= COLLECT;
              rank   <= '0;
              count  <= '0;
              done_o <= 1'b1;
              for (int i = 0; i < K; i++) begin
                s_fx[i]  <= '1;
                s_d0[i]  <= '0;
                s_d1[i]  <= '0;
                s_d2[i]  <= '0;
                s_idx[i] <= '0;
              end
            end else begin
              rank <= rank + RW'(1);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign fx_best_o     = s_fx[0];
  assign p0_idx_best_o = s_idx[0];
  assign count_o       = count;
  assign out_valid_o   = (state == DRAIN);
  assign out_fx        = s_fx[rank];
  assign out_d0        = s_d0[rank];
  assign out_d1        = s_d1[rank];
  assign out_d2        = s_d2[rank];
  assign out_idx       = s_idx[rank];
  assign out_rank      = rank;
  assign out_last      = last_c;

`ifdef SOLUTION_TOPK_DROP_CNT_EN
  logic [15:0] drop_cnt;

  // Saturating count of candidates presented while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if ((state == DRAIN) && valid_i && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_solution_topk.sv
// Randomised scoreboard bench for solution_topk against a queue-based ranked-list model.
module tb_solution_topk;

  localparam int unsigned PD = 12, P = 22, K = 4, IDX_W = 8;
  localparam int unsigned DW = PD + P, FW = 3 + P;
  localparam logic [FW-1:0] FX_ONES = '1;
`ifdef SOLUTION_TOPK_DROP_CNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  typedef struct {
    logic [FW-1:0]    fx;
    logic [DW-1:0]    d0, d1, d2;
    logic [IDX_W-1:0] idx;
  } ent_t;

  typedef struct {
    ent_t e;
    int   rank;
    bit   last;
  } beat_t;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             valid_i = 1'b0, eval_done_i = 1'b0, out_ready_i = 1'b0;
  logic [DW-1:0]    d0_res = '0, d1_res = '0, d2_res = '0;
  logic [FW-1:0]    fx_res = '0;
  logic [IDX_W-1:0] p0_idx_i = '0;
  logic [FW-1:0]    fx_best_o, out_fx;
  logic [IDX_W-1:0] p0_idx_best_o, out_idx;
  logic [2:0]       count_o;
  logic             out_valid_o, out_last, done_o;
  logic [DW-1:0]    out_d0, out_d1, out_d2;
  logic [1:0]       out_rank;
  logic [15:0]      drop_cnt_o;

  int   n_chk = 0, n_fail = 0;
  ent_t  model[$];
  beat_t exp_q[$];

  always #5 clk = ~clk;

  solution_topk #(.PD(PD), .P(P), .K(K), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
    .d0_res(d0_res), .d1_res(d1_res), .d2_res(d2_res), .fx_res(fx_res),
    .p0_idx_i(p0_idx_i), .eval_done_i(eval_done_i),
    .fx_best_o(fx_best_o), .p0_idx_best_o(p0_idx_best_o), .count_o(count_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_d0(out_d0), .out_d1(out_d1), .out_d2(out_d2), .out_fx(out_fx),
    .out_idx(out_idx), .out_rank(out_rank), .out_last(out_last),
    .done_o(done_o), .drop_cnt_o(drop_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Ranked insertion: new entry goes after every existing entry with fx <= its fx.
  function automatic void model_ins(input ent_t e);
    int pos = 0;
    foreach (model[i]) if (model[i].fx <= e.fx) pos++;
    if (pos < K) begin
      model.insert(pos, e);
      if (model.size() > K) void'(model.pop_back());
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cand(input logic [FW-1:0] fx, input logic [IDX_W-1:0] idx);
    ent_t e;
    e.fx = fx; e.idx = idx;
    e.d0 = DW'({$urandom(), $urandom()});
    e.d1 = DW'({$urandom(), $urandom()});
    e.d2 = DW'({$urandom(), $urandom()});
    valid_i = 1'b1; fx_res = fx; p0_idx_i = idx;
    d0_res = e.d0; d1_res = e.d1; d2_res = e.d2;
    model_ins(e);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, 64'(count_o), 64'(model.size()));
    chk({tag, "_fx_best"}, 64'(fx_best_o), 64'(model.size() > 0 ? model[0].fx : FX_ONES));
    chk({tag, "_idx_best"}, 64'(p0_idx_best_o), 64'(model.size() > 0 ? model[0].idx : '0));
  endtask

  task automatic put(input logic [FW-1:0] fx, input logic [IDX_W-1:0] idx);
    set_cand(fx, idx);
    step();
    valid_i = 1'b0;
  endtask

  // mode 0: ready high; 1: low 2 cycles then high; 2: random; 3: low 4 cycles with 3 dropped candidates
  task automatic drain(input bit cand, input logic [FW-1:0] fx, input logic [IDX_W-1:0] idx,
                       input int mode);
    int n;
    if (cand) set_cand(fx, idx);
    eval_done_i = 1'b1;
    n = model.size();
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.e = model[i]; b.rank = i; b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    model.delete();
    step();
    valid_i = 1'b0; eval_done_i = 1'b0;
    chk("first_beat_valid", 64'(out_valid_o), 64'(n > 0));
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      case (mode)
        0: out_ready_i = 1'b1;
        1: out_ready_i = (c >= 2);
        2: out_ready_i = 1'($urandom_range(0, 1));
        default: begin
          out_ready_i = (c >= 4);
          valid_i = (c < 3);
          fx_res = FW'(1);
        end
      endcase
      step();
    end
    valid_i = 1'b0; out_ready_i = 1'b0;
    chk("drain_timeout_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("done_pulse", 64'(done_o), 64'd1);
    chk("post_valid", 64'(out_valid_o), 64'd0);
    check_model("post_drain");
    step();
    chk("done_clear", 64'(done_o), 64'd0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks payload holds under backpressure.
  logic held = 1'b0;
  logic [FW-1:0] h_fx; logic [IDX_W-1:0] h_idx; logic [1:0] h_rank; logic [DW-1:0] h_d0;
  always @(negedge clk) begin
    if (rst_n && out_valid_o) begin
      if (held) begin
        chk("hold_fx", 64'(out_fx), 64'(h_fx));
        chk("hold_idx", 64'(out_idx), 64'(h_idx));
        chk("hold_rank", 64'(out_rank), 64'(h_rank));
        chk("hold_d0", 64'(out_d0), 64'(h_d0));
      end
      h_fx = out_fx; h_idx = out_idx; h_rank = out_rank; h_d0 = out_d0;
      held = !out_ready_i;
      if (out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          chk("beat_fx", 64'(out_fx), 64'(b.e.fx));
          chk("beat_idx", 64'(out_idx), 64'(b.e.idx));
          chk("beat_d0", 64'(out_d0), 64'(b.e.d0));
          chk("beat_d1", 64'(out_d1), 64'(b.e.d1));
          chk("beat_d2", 64'(out_d2), 64'(b.e.d2));
          chk("beat_rank", 64'(out_rank), 64'(b.rank));
          chk("beat_last", 64'(out_last), 64'(b.last));
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #12;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_drop", 64'(drop_cnt_o), 64'd0);
    check_model("rst");
    @(negedge clk); rst_n = 1'b1;
    step();

    put(25'd50, 8'd1); check_model("ins50");
    put(25'd20, 8'd2); check_model("ins20");
    put(25'd80, 8'd3); check_model("ins80");
    put(25'd20, 8'd7); check_model("ins20b");
    put(25'd10, 8'd5); check_model("ins10");
    chk("best_10", 64'(fx_best_o), 64'd10);
    chk("full_count", 64'(count_o), 64'd4);
    put(25'd50, 8'd9); check_model("rej50");
    put(25'd60, 8'd9); check_model("rej60");
    put(25'd30, 8'd4); check_model("ins30");
    drain(1'b0, '0, '0, 0);

    put(25'd33, 8'd1); put(FX_ONES, 8'd2); put(25'd12, 8'd3);
    check_model("three");
    drain(1'b0, '0, '0, 1);

    put(25'd40, 8'd1); put(25'd9, 8'd2);
    drain(1'b1, 25'd5, 8'd6, 0);
    drain(1'b0, '0, '0, 0);

    put(25'd70, 8'd1); put(25'd2, 8'd2);
    drain(1'b0, '0, '0, 3);
    chk("drop_cnt", 64'(drop_cnt_o), 64'(EXP_DROP));

    put(25'd15, 8'd1); put(25'd16, 8'd2); put(25'd3, 8'd3);
    eval_done_i = 1'b1;
    model.delete();
    step();
    eval_done_i = 1'b0;
    chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid_drop", 64'(out_valid_o), 64'd0);
    chk("rst_drop2", 64'(drop_cnt_o), 64'd0);
    check_model("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("no_done_after_rst", 64'(done_o), 64'd0);
    check_model("after_rst");

    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(0, 9);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          step();
        end else begin
          logic [FW-1:0] fx;
          fx = ($urandom_range(0, 9) == 9) ? FX_ONES : FW'($urandom_range(0, 40));
          put(fx, IDX_W'($urandom_range(0, 255)));
        end
        check_model("rnd");
      end
      drain($urandom_range(0, 3) == 0, FW'($urandom_range(0, 40)),
            IDX_W'($urandom_range(0, 255)), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
